mux_select_arbiter_16_bit: RTL and testbench
============================================

Name: mux_select_arbiter_16_bit

Overview:
- Arbitrates two 16-bit requesters for one shared 2:1 16-bit select path and registers the winning word.
- Drives the select line of the 16-bit 2:1 multiplexer. sel=0 routes requester 0 (I0); sel=1 routes requester 1 (I1).
- Used where two datapath sources compete for one write-back or bus input.
- Round-robin arbitration, with optional bounded lock for multi-cycle bursts.

Parameters:
- HOLD_MAX, default 4: maximum consecutive grant cycles a locked requester keeps the path while the other requester is waiting. Legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- req0  input  1  requester 0 requests the path
- req1  input  1  requester 1 requests the path
- lock0  input  1  requester 0 asks to keep the grant (burst)
- lock1  input  1  requester 1 asks to keep the grant (burst)
- data0  input  16  requester 0 data word
- data1  input  16  requester 1 data word
- gnt0  output  1  requester 0 owns the path this cycle
- gnt1  output  1  requester 1 owns the path this cycle
- sel  output  1  mux select; 1 = requester 1
- out_valid  output  1  out_data holds a word transferred last cycle
- out_data  output  16  registered transferred word
- busy  output  1  high when the FSM is not in IDLE

Behaviour:
- Reset (rst_n=0, takes effect immediately, asynchronous):
  - gnt0=gnt1=0, sel=0, out_valid=0, out_data=16'h0000, busy=0.
  - FSM=IDLE, hold_cnt=0, last=1, so requester 0 wins the first contention.
- States: IDLE, G0, G1. Every output is a registered function of state; nothing is combinational from the inputs.
  - gnt0 = (state==G0); gnt1 = (state==G1); sel = (state==G1); busy = (state!=IDLE).
- Grant latency: a request sampled at edge N gives a grant visible after edge N; minimum 1 cycle from IDLE.
- Transfer rule: a cycle with gntX=1 and reqX=1 is a transfer.
  - At the next edge: out_data<=dataX and out_valid<=1.
  - Any other cycle: out_valid<=0 and out_data holds its value.
- IDLE transitions:
  - One request present: go to that requester's state.
  - Both requests: go to the requester that is not `last`.
  - No request: stay in IDLE.
- GX transitions, evaluated each edge with other = 1-X:
  - reqX=0: go to G(other) if req_other, else IDLE. Set last<=X. Set hold_cnt<=0.
  - reqX=1, lockX=1, req_other=1, hold_cnt<HOLD_MAX-1: stay in GX; hold_cnt++.
  - reqX=1, req_other=1, and either lockX=0 or hold_cnt==HOLD_MAX-1: switch to G(other) (forced rotation). Set last<=X. Set hold_cnt<=0.
  - reqX=1, req_other=0: stay in GX. hold_cnt<=0, because no contention means no starvation risk.
- Fairness bound: a waiting requester is granted within HOLD_MAX+1 cycles of asserting its request.
- lockX is ignored unless gntX=1.
- Dropping a request mid-burst releases the path at the next edge; that cycle is not a transfer.
- Reset asserted mid-burst aborts the burst with no further transfer. out_valid clears immediately.
- Requests are sampled only at the clock edge; glitches between edges have no effect.

Optional Feature:
- Macro ARB_FIXED_PRIORITY_EN.
- Defined:
  - Requester 0 wins every contention: from IDLE, and at every G1 decision where req0=1, G1 goes to G0 regardless of lock1 or hold_cnt.
  - Requester 0's lock has no HOLD_MAX bound; it keeps G0 while req0=1.
  - `last` is unused.
- Undefined: round-robin behaviour as specified above.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with req0=1 → all outputs 0 without waiting for a clock edge. Release → G0 one edge after req0 is sampled.
- Single requester: req1=1, data1=16'hBEEF for 3 cycles.
  - Response: gnt1=1 and sel=1 from cycle 1.
  - out_valid=1 with out_data=16'hBEEF on cycles 2-4, then 0 one cycle after req1 drops.
- Round-robin: req0=req1=1, no lock, data0=16'h1111, data1=16'h2222.
  - Response: grants alternate G0,G1,G0,G1.
  - out_data sequence 1111,2222,1111,2222.
- Bounded lock: HOLD_MAX=4, req0=lock0=1 and req1=1 held throughout.
  - Response: G0 for exactly 4 cycles, then G1.
  - Never more than 5 cycles from req1 assertion to gnt1.
- Release mid-burst: G0 with lock0=1, req1=1; drop req0 after 2 cycles → G1 at the next edge, and no transfer is recorded on the drop cycle.
- With ARB_FIXED_PRIORITY_EN: G1 active, req0 asserts → G0 at the next edge. Both requesting continuously → gnt1 never rises.

Source files
------------

// File: rtl/mux_select_arbiter_16_bit.sv
// ---------------------------------------------------------------------------
// mux_select_arbiter_16_bit
//   Arbitrates two 16-bit requesters for one shared 2:1 select path. It drives
//   the mux select and registers the word transferred on each granted cycle.
//   The default build uses round-robin arbitration with a bounded burst lock.
//   Defining ARB_FIXED_PRIORITY_EN gives requester 0 strict priority, and its
//   lock is then unbounded.
//
// Parameters
//   HOLD_MAX  : maximum consecutive locked grant cycles while the other side
//               waits (1..15)
// Ports
//   clk, rst_n      : rising-edge clock, async active-low reset
//   req0/req1       : path requests
//   lock0/lock1     : keep-grant (burst) requests, honoured only while granted
//   data0/data1     : requester data words
//   gnt0/gnt1       : registered grants (state == G0 / G1)
//   sel             : mux select, 1 = requester 1
//   out_valid       : out_data holds a word transferred last cycle
//   out_data        : registered transferred word
//   busy            : FSM not in IDLE
// ---------------------------------------------------------------------------
module mux_select_arbiter_16_bit #(
    parameter int HOLD_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        lock0,
    input  logic        lock1,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        sel,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic        busy
);

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, G0 = 2'd1, G1 = 2'd2} state_t;

    state_t     state, state_nxt;
    logic [3:0] hold_cnt, hold_nxt;
    logic       last, last_nxt;

    // Next-state decision. The outputs below are registered copies of
    // state_nxt, so each output equals a function of the current state.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        last_nxt  = last;
`ifdef ARB_FIXED_PRIORITY_EN
        hold_nxt = 4'd0;
        case (state)
            IDLE: begin
                if (req0)      state_nxt = G0;
                else if (req1) state_nxt = G1;
            end
            G0: begin
                if (!req0) state_nxt = req1 ? G1 : IDLE;
            end
            G1: begin
                // Requester 0 preempts regardless of lock1.
                if (req0)       state_nxt = G0;
                else if (!req1) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
`else
        case (state)
            IDLE: begin
                // On contention, the requester that was not served last wins.
                if (req0 && req1) state_nxt = last ? G0 : G1;
                else if (req0)    state_nxt = G0;
                else if (req1)    state_nxt = G1;
            end
            G0: begin
                if (!req0) begin
                    state_nxt = req1 ? G1 : IDLE;
                    last_nxt  = 1'b0;
                    hold_nxt  = 4'd0;
                end else if (!req1) begin
                    // No contention, so there is no starvation to bound.
                    hold_nxt = 4'd0;
                end else if (lock0 && hold_cnt < HOLD_LAST) begin
                    hold_nxt = hold_cnt + 4'd1;
                end else begin
                    state_nxt = G1;
                    last_nxt  = 1'b0;
                    hold_nxt  = 4'd0;
                end
            end
            G1: begin
                if (!req1) begin
                    state_nxt = req0 ? G0 : IDLE;
                    last_nxt  = 1'b1;
                    hold_nxt  = 4'd0;
                end else if (!req0) begin
                    hold_nxt = 4'd0;
                end else if (lock1 && hold_cnt < HOLD_LAST) begin
                    hold_nxt = hold_cnt + 4'd1;
                end else begin
                    state_nxt = G0;
                    last_nxt  = 1'b1;
                    hold_nxt  = 4'd0;
                end
            end
            default: begin
                state_nxt = IDLE;
                hold_nxt  = 4'd0;
            end
        endcase
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold_cnt  <= 4'd0;
            last      <= 1'b1;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            sel       <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 16'h0000;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            last     <= last_nxt;
            gnt0     <= (state_nxt == G0);
            gnt1     <= (state_nxt == G1);
            sel      <= (state_nxt == G1);
            busy     <= (state_nxt != IDLE);
            // A transfer is a granted cycle whose owner is still requesting.
            if (state == G0 && req0) begin
                out_data  <= data0;
                out_valid <= 1'b1;
            end else if (state == G1 && req1) begin
                out_data  <= data1;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_select_arbiter_16_bit.sv
module tb_mux_select_arbiter_16_bit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, lock0, lock1;
    logic [15:0] data0, data1;
    logic        gnt0, gnt1, sel, out_valid, busy;
    logic [15:0] out_data;

    int checks   = 0;
    int failures = 0;

    mux_select_arbiter_16_bit #(.HOLD_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .data0(data0), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1), .sel(sel),
        .out_valid(out_valid), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Packs {gnt0,gnt1,sel,busy,out_valid}.
    function automatic logic [4:0] ctl();
        return {gnt0, gnt1, sel, busy, out_valid};
    endfunction

    initial begin
        rst_n = 1'b0; req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
        data0 = 16'h0000; data1 = 16'h0000;

        // Reset state
        #3;
        chk("reset_ctl", 32'(ctl()), 32'h0);
        chk("reset_data", 32'(out_data), 32'h0);
        #4 rst_n = 1'b1;                       // released at t=7, between edges
        step();
        chk("idle_ctl", 32'(ctl()), 32'h0);

        // Grant, then asynchronous reset mid-burst
        req0 = 1; data0 = 16'hA5A5;
        step();
        chk("g0_grant", 32'(ctl()), 32'b10010);
        step();
        chk("g0_xfer", 32'({out_valid, out_data}), {15'd0, 1'b1, 16'hA5A5});
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ctl", 32'(ctl()), 32'h0);
        chk("async_rst_data", 32'(out_data), 32'h0);
        #2 rst_n = 1'b1;                       // req0 still high
        step();
        chk("post_rst_g0", 32'(ctl()), 32'b10010);
        req0 = 0;
        step();
        chk("drop_idle", 32'(ctl()), 32'h0);   // no transfer on drop cycle

        // Single requester
        req1 = 1; data1 = 16'hBEEF;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk($sformatf("single_ctl_%0d", i), 32'(ctl()), {27'd0, 4'b0111, (i >= 2)});
            if (i >= 2) chk($sformatf("single_data_%0d", i), 32'(out_data), 32'hBEEF);
        end
        req1 = 0;
        step();
        chk("single_end", 32'(ctl()), 32'h0);

        // Requests between edges are invisible
        req0 = 1; #2 req0 = 0;
        step();
        chk("glitch", 32'(ctl()), 32'h0);

`ifndef ARB_FIXED_PRIORITY_EN
        // Round-robin without lock (last=1 after requester 1 ended)
        req0 = 1; req1 = 1; data0 = 16'h1111; data1 = 16'h2222;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("rr_gnt_%0d", k), 32'({gnt0, gnt1}), (k % 2 == 1) ? 32'b10 : 32'b01);
            if (k >= 2)
                chk($sformatf("rr_data_%0d", k), 32'({out_valid, out_data}),
                    {15'd0, 1'b1, (k % 2 == 0) ? 16'h1111 : 16'h2222});
        end
        req0 = 0; req1 = 0;
        step();
        chk("rr_end", 32'(ctl()), 32'h0);

        // Bounded lock, HOLD_MAX=4
        req0 = 1; lock0 = 1;
        step();
        chk("lock_g0_1", 32'({gnt0, gnt1}), 32'b10);
        req1 = 1;                              // req1 asserted here
        for (int k = 2; k <= 4; k++) begin
            step();
            chk($sformatf("lock_g0_%0d", k), 32'({gnt0, gnt1}), 32'b10);
        end
        step();                                // 4th edge after req1 assertion
        chk("lock_rotate_g1", 32'({gnt0, gnt1, sel}), 32'b011);
        chk("lock_data", 32'(out_data), 32'h1111);
        req0 = 0; lock0 = 0; req1 = 0;
        step();
        chk("lock_end", 32'(ctl()), 32'h0);

        // Release mid-burst (last=1 so requester 0 wins)
        req0 = 1; lock0 = 1; req1 = 1; data0 = 16'h3333; data1 = 16'h4444;
        step();
        chk("rel_g0_1", 32'({gnt0, gnt1}), 32'b10);
        step();
        chk("rel_g0_2", 32'({gnt0, gnt1, out_valid}), 32'b101);
        req0 = 0;
        step();
        chk("rel_g1", 32'({gnt0, gnt1, out_valid}), 32'b010);
        chk("rel_hold_data", 32'(out_data), 32'h3333);
        step();
        chk("rel_g1_xfer", 32'({out_valid, out_data}), {15'd0, 1'b1, 16'h4444});
        req1 = 0; lock0 = 0;
        step();
`else
        // Fixed priority: requester 0 preempts a locked G1
        req1 = 1; lock1 = 1;
        step();
        chk("fp_g1", 32'({gnt0, gnt1}), 32'b01);
        req0 = 1;
        step();
        chk("fp_preempt", 32'({gnt0, gnt1}), 32'b10);
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("fp_hold_%0d", k), 32'({gnt0, gnt1}), 32'b10);
        end
        req0 = 0; req1 = 0; lock1 = 0;
        step();
`endif
        chk("final_idle", 32'(busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
